kernel_weight_fetch: RTL and testbench

- Sits directly downstream of the kernel BRAM control unit and the kernel BRAM port B.
- Owns the port-B read side: pulses update_BRAM_doutb to advance the kernel BRAM read address by one channel, waits for the control unit and the BRAM to settle, then latches doutb into a held weight register for the conv MAC array.
- Tracks the channel index of the held word and reports channel wrap from the control unit's last_channel pulse.

---
 rtl/kernel_weight_fetch_pkg.sv | 24 ++
 rtl/kernel_weight_fetch_if.sv | 29 ++
 rtl/kernel_weight_fetch_delay_counter.sv | 27 ++
 rtl/kernel_weight_fetch.sv | 159 +++++++++++++++
 tb/tb_kernel_weight_fetch.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/kernel_weight_fetch_pkg.sv
// Shared definitions for the kernel weight fetch unit: word geometry, FSM
// encoding and the fetch-mode flag.
package kernel_weight_fetch_pkg;

    localparam int KER_WORD_W = 144;
    localparam int WEIGHT_W   = 16;
    localparam int N_WEIGHTS  = KER_WORD_W / WEIGHT_W;
    localparam int CH_W       = 9;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_CU   = 3'd2,
        ST_WAIT_BRAM = 3'd3,
        ST_CAPTURE   = 3'd4
    } state_t;

    typedef enum logic {
        MODE_PRIME = 1'b0,
        MODE_ADV   = 1'b1
    } mode_t;

endpackage

// File: rtl/kernel_weight_fetch_if.sv
// Signal bundle between the kernel BRAM side / sequencer and the weight fetch unit.
interface kernel_weight_fetch_if;
    import kernel_weight_fetch_pkg::*;

    logic                  prime;
    logic                  advance;
    logic [KER_WORD_W-1:0] ker_doutb;
    logic                  last_channel_in;
    logic                  update_BRAM_doutb;
    logic [KER_WORD_W-1:0] weights;
    logic                  weights_valid;
    logic [CH_W-1:0]       chan_idx;
    logic                  kernel_wrap;
    logic                  busy;
    logic                  req_overrun;

    modport slave (
        input  prime, advance, ker_doutb, last_channel_in,
        output update_BRAM_doutb, weights, weights_valid, chan_idx,
               kernel_wrap, busy, req_overrun
    );

    modport master (
        output prime, advance, ker_doutb, last_channel_in,
        input  update_BRAM_doutb, weights, weights_valid, chan_idx,
               kernel_wrap, busy, req_overrun
    );

endinterface

// File: rtl/kernel_weight_fetch_delay_counter.sv
// Loadable down-counter with a zero flag; shared by the control-unit settle
// and BRAM latency wait phases.
module fetch_delay_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/kernel_weight_fetch.sv
// Port-B read sequencer: requests an address advance, waits for the control
// unit and BRAM to settle, then holds the captured kernel word for the MAC array.
module kernel_weight_fetch
    import kernel_weight_fetch_pkg::*;
#(
    parameter int BRAM_LATENCY = 2,
    parameter int CU_SETTLE    = 3
) (
    input  logic                 clk,
    input  logic                 Reset,
    kernel_weight_fetch_if.slave bus
);

    localparam logic [CNT_W-1:0] CU_LOAD   = CNT_W'(CU_SETTLE - 1);
    localparam logic [CNT_W-1:0] BRAM_LOAD = CNT_W'(BRAM_LATENCY - 1);

    state_t            state_reg, state_next;
    mode_t             mode_reg, mode_next;
    logic              wrap_flag_reg;
    logic              weights_valid_reg;
    logic              kernel_wrap_reg;
    logic              req_overrun_reg;
    logic [CH_W-1:0]   chan_idx_reg;

    logic              accept;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_zero;
    logic              is_idle, is_capture, req_any;

    assign is_idle    = (state_reg == ST_IDLE);
    assign is_capture = (state_reg == ST_CAPTURE);
    assign req_any    = bus.prime | bus.advance;

    fetch_delay_counter #(.W(CNT_W)) u_delay (
        .clk      (clk),
        .Reset    (Reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_reg <= ST_IDLE;
            mode_reg  <= MODE_PRIME;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mode_next    = mode_reg;
        accept       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_reg)
            ST_IDLE: begin
                // prime has priority; a simultaneous advance is dropped
                if (bus.prime) begin
                    state_next   = ST_WAIT_BRAM;
                    mode_next    = MODE_PRIME;
                    accept       = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = BRAM_LOAD;
                end else if (bus.advance) begin
                    state_next = ST_REQ;
                    mode_next  = MODE_ADV;
                    accept     = 1'b1;
                end
            end
            ST_REQ: begin
                state_next   = ST_WAIT_CU;
                cnt_load     = 1'b1;
                cnt_load_val = CU_LOAD;
            end
            ST_WAIT_CU: begin
                if (cnt_zero) begin
                    state_next   = ST_WAIT_BRAM;
                    cnt_load     = 1'b1;
                    cnt_load_val = BRAM_LOAD;
                end
            end
            ST_WAIT_BRAM: begin
                if (cnt_zero) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            wrap_flag_reg     <= 1'b0;
            weights_valid_reg <= 1'b0;
            kernel_wrap_reg   <= 1'b0;
            req_overrun_reg   <= 1'b0;
            chan_idx_reg      <= '0;
        end else begin
            if (is_capture) begin
                wrap_flag_reg <= 1'b0;
            end else if (state_reg == ST_WAIT_CU && bus.last_channel_in) begin
                wrap_flag_reg <= 1'b1;
            end

            if (accept) begin
                weights_valid_reg <= 1'b0;
            end else if (is_capture) begin
                weights_valid_reg <= 1'b1;
            end

            if (is_capture) begin
                if (mode_reg == MODE_ADV && !wrap_flag_reg) begin
                    chan_idx_reg <= chan_idx_reg + CH_W'(1);
                end else begin
                    chan_idx_reg <= '0;
                end
            end

            kernel_wrap_reg <= is_capture && (mode_reg == MODE_ADV) && wrap_flag_reg;

            if (req_any && (!is_idle || (bus.prime && bus.advance))) begin
                req_overrun_reg <= 1'b1;
            end
        end
    end

    // Held word is kept as per-weight lanes so each 16-bit field has its own register.
    genvar gi;
    generate
        for (gi = 0; gi < N_WEIGHTS; gi++) begin : g_lane
            logic [WEIGHT_W-1:0] lane_reg;
            always_ff @(posedge clk) begin
                if (!Reset) begin
                    lane_reg <= '0;
                end else if (is_capture) begin
                    lane_reg <= bus.ker_doutb[gi*WEIGHT_W +: WEIGHT_W];
                end
            end
            assign bus.weights[gi*WEIGHT_W +: WEIGHT_W] = lane_reg;
        end
    endgenerate

    assign bus.update_BRAM_doutb = (state_reg == ST_REQ);
    assign bus.busy              = !is_idle;
    assign bus.weights_valid     = weights_valid_reg;
    assign bus.chan_idx          = chan_idx_reg;
    assign bus.kernel_wrap       = kernel_wrap_reg;
    assign bus.req_overrun       = req_overrun_reg;

endmodule

// File: tb/tb_kernel_weight_fetch.sv
// Directed bench for kernel_weight_fetch: vector table of fetch requests plus
// hand sequences for overrun and mid-operation reset.
module tb_kernel_weight_fetch;
    import kernel_weight_fetch_pkg::*;

    typedef struct {
        logic                  is_adv;
        int                    lc_at;
        logic [KER_WORD_W-1:0] word;
        int                    lat;
        logic [CH_W-1:0]       exp_chan;
        logic                  exp_wrap;
    } vec_t;

    logic clk = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   upd_total = 0;

    kernel_weight_fetch_if bus();

    kernel_weight_fetch #(
        .BRAM_LATENCY (2),
        .CU_SETTLE    (3)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.update_BRAM_doutb === 1'b1) upd_total <= upd_total + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [KER_WORD_W-1:0] act,
                       input logic [KER_WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic is_adv, input int lc_at, input logic [15:0] h,
                                input logic [CH_W-1:0] chan, input logic wrap);
        vec_t v;
        v.is_adv   = is_adv;
        v.lc_at    = lc_at;
        v.word     = {9{h}};
        v.lat      = is_adv ? 8 : 4;
        v.exp_chan = chan;
        v.exp_wrap = wrap;
        return v;
    endfunction

    // Request in the current cycle (0); word presented only in the capture cycle.
    task automatic run_vec(input vec_t v, input string tag);
        logic [KER_WORD_W-1:0] junk;
        junk = ~v.word;
        bus.prime           = !v.is_adv;
        bus.advance         = v.is_adv;
        bus.ker_doutb       = junk;
        bus.last_channel_in = (v.lc_at == 0);
        for (int k = 1; k <= v.lat; k++) begin
            tick();
            bus.prime           = 1'b0;
            bus.advance         = 1'b0;
            bus.last_channel_in = (v.lc_at == k);
            bus.ker_doutb       = (k == v.lat - 1) ? v.word : junk;
            chk($sformatf("%s_upd_c%0d", tag, k), KER_WORD_W'(bus.update_BRAM_doutb),
                KER_WORD_W'(v.is_adv && k == 1));
            chk($sformatf("%s_valid_c%0d", tag, k), KER_WORD_W'(bus.weights_valid),
                KER_WORD_W'(k == v.lat));
            chk($sformatf("%s_busy_c%0d", tag, k), KER_WORD_W'(bus.busy),
                KER_WORD_W'(k < v.lat));
            chk($sformatf("%s_wrap_c%0d", tag, k), KER_WORD_W'(bus.kernel_wrap),
                KER_WORD_W'(k == v.lat && v.exp_wrap));
        end
        chk({tag, "_weights"}, bus.weights, v.word);
        chk({tag, "_chan"}, KER_WORD_W'(bus.chan_idx), KER_WORD_W'(v.exp_chan));
        // idle gap cycle: last_channel_in here must be ignored
        bus.last_channel_in = 1'b1;
        tick();
        bus.last_channel_in = 1'b0;
        chk({tag, "_gap_valid"}, KER_WORD_W'(bus.weights_valid), KER_WORD_W'(1));
        chk({tag, "_gap_busy"}, KER_WORD_W'(bus.busy), KER_WORD_W'(0));
        chk({tag, "_gap_wrap"}, KER_WORD_W'(bus.kernel_wrap), KER_WORD_W'(0));
        chk({tag, "_gap_weights"}, bus.weights, v.word);
        $display("txn %s adv=%0b lc_at=%0d chan=%0d wrap=%0b weights=%h", tag, v.is_adv,
                 v.lc_at, bus.chan_idx, v.exp_wrap, bus.weights);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_weights"}, bus.weights, '0);
        chk({tag, "_valid"}, KER_WORD_W'(bus.weights_valid), '0);
        chk({tag, "_chan"}, KER_WORD_W'(bus.chan_idx), '0);
        chk({tag, "_upd"}, KER_WORD_W'(bus.update_BRAM_doutb), '0);
        chk({tag, "_wrap"}, KER_WORD_W'(bus.kernel_wrap), '0);
        chk({tag, "_overrun"}, KER_WORD_W'(bus.req_overrun), '0);
        chk({tag, "_busy"}, KER_WORD_W'(bus.busy), '0);
    endtask

    vec_t vecs[9];
    vec_t v;

    initial begin
        bus.prime           = 1'b0;
        bus.advance         = 1'b0;
        bus.ker_doutb       = '1;
        bus.last_channel_in = 1'b0;

        vecs[0] = mk(1'b0, -1, 16'hA5A5, 9'd0, 1'b0);
        vecs[1] = mk(1'b1, -1, 16'h1111, 9'd1, 1'b0);
        vecs[2] = mk(1'b1, -1, 16'h2222, 9'd2, 1'b0);
        vecs[3] = mk(1'b1, -1, 16'h3333, 9'd3, 1'b0);
        vecs[4] = mk(1'b1,  3, 16'h4444, 9'd0, 1'b1);
        vecs[5] = mk(1'b1,  1, 16'h5555, 9'd1, 1'b0);
        vecs[6] = mk(1'b1,  2, 16'h6666, 9'd0, 1'b1);
        vecs[7] = mk(1'b1,  4, 16'h7777, 9'd0, 1'b1);
        vecs[8] = mk(1'b1,  5, 16'h8888, 9'd1, 1'b0);

        repeat (3) tick();
        chk_all_zero("reset");
        $display("txn reset outputs checked");
        Reset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end
        chk("no_overrun_yet", KER_WORD_W'(bus.req_overrun), '0);

        // prime+advance together, then advance while busy: behaves as a single prime
        bus.prime = 1'b1;
        bus.advance = 1'b1;
        bus.ker_doutb = '1;
        tick();
        bus.prime = 1'b0;
        bus.advance = 1'b0;
        chk("ovr_flag_c1", KER_WORD_W'(bus.req_overrun), KER_WORD_W'(1));
        chk("ovr_busy_c1", KER_WORD_W'(bus.busy), KER_WORD_W'(1));
        tick();
        bus.advance = 1'b1;
        chk("ovr_upd_c2", KER_WORD_W'(bus.update_BRAM_doutb), '0);
        tick();
        bus.advance = 1'b0;
        bus.ker_doutb = {9{16'hC3C3}};
        chk("ovr_valid_c3", KER_WORD_W'(bus.weights_valid), '0);
        tick();
        bus.ker_doutb = '1;
        chk("ovr_valid_c4", KER_WORD_W'(bus.weights_valid), KER_WORD_W'(1));
        chk("ovr_weights", bus.weights, {9{16'hC3C3}});
        chk("ovr_chan", KER_WORD_W'(bus.chan_idx), '0);
        for (int k = 5; k < 13; k++) begin
            tick();
            chk($sformatf("ovr_idle_busy_c%0d", k), KER_WORD_W'(bus.busy), '0);
            chk($sformatf("ovr_idle_valid_c%0d", k), KER_WORD_W'(bus.weights_valid),
                KER_WORD_W'(1));
        end
        chk("ovr_sticky", KER_WORD_W'(bus.req_overrun), KER_WORD_W'(1));
        $display("txn overrun prime+advance chan=%0d overrun=%0b", bus.chan_idx, bus.req_overrun);

        v = mk(1'b1, -1, 16'h9999, 9'd1, 1'b0);
        run_vec(v, "pre_rst");

        // reset asserted while in WAIT_BRAM (cycles 5..6 of an advance)
        bus.advance = 1'b1;
        tick();
        bus.advance = 1'b0;
        repeat (4) tick();
        chk("rst_mid_busy_c5", KER_WORD_W'(bus.busy), KER_WORD_W'(1));
        Reset = 1'b0;
        tick();
        chk_all_zero("rst_mid");
        Reset = 1'b1;
        tick();
        chk("rst_after_busy", KER_WORD_W'(bus.busy), '0);
        $display("txn reset during WAIT_BRAM");

        v = mk(1'b0, -1, 16'h5A5A, 9'd0, 1'b0);
        run_vec(v, "post_rst");

        chk("upd_pulse_total", KER_WORD_W'(upd_total), KER_WORD_W'(10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
